// File: rtl/btn_encoder_8to3.sv
// Eight-button front end: 2-FF synchroniser, whole-vector debounce, priority encoder and a
// one-event-per-press valid/ack handshake with a sticky overflow flag.
module btn_encoder_8to3 #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] btn_raw,
  input  logic       ack,
  output logic [2:0] code,
  output logic       valid,
  output logic       dropped,
  output logic       pressed
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {StIdle, StHeld} state_e;

  logic [7:0]       sync1_q, sync2_q;
  logic [7:0]       samp_q, samp_d;
  logic [7:0]       stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_q, pressed_d;
  logic [2:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             dropped_q, dropped_d;
  state_e           state_q, state_d;
  logic [2:0]       enc;
  logic             issue;

  // Debounce: any change in the synchronised vector restarts the window; cnt saturates.
  always_comb begin
    samp_d   = samp_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q != samp_q) begin
      samp_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CntMax) begin
      stable_d = samp_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign pressed_d = |stable_q;

  // Highest-numbered pressed button wins.
  always_comb begin
    enc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (stable_q[i]) enc = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      StIdle: begin
        if (stable_q != 8'd0) begin
          issue   = 1'b1;
          state_d = StHeld;
        end
      end
      StHeld: begin
        if (stable_q == 8'd0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Ack is applied before a same-edge issue, so an acked slot can be refilled immediately.
  always_comb begin
    code_d    = code_q;
    valid_d   = valid_q;
    dropped_d = dropped_q;
    if (ack && valid_q) begin
      valid_d   = 1'b0;
      dropped_d = 1'b0;
    end
    if (issue) begin
      if (!valid_d) begin
        code_d  = enc;
        valid_d = 1'b1;
      end else begin
        dropped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      samp_q    <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      code_q    <= 3'd0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
      state_q   <= StIdle;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      samp_q    <= samp_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
      state_q   <= state_d;
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign dropped = dropped_q;
  assign pressed = pressed_q;

endmodule

// File: tb/tb_btn_encoder_8to3.sv
// Bench for btn_encoder_8to3: directed scenarios plus randomized hold/glitch sequences, with
// expected event codes queued at stimulus time and checked by an independent monitor.
module tb_btn_encoder_8to3;

  localparam int unsigned Deb = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] btn_raw = 8'd0;
  logic       ack;
  logic       dir_ack = 1'b0;
  logic       mon_ack = 1'b0;
  logic       auto_ack = 1'b0;
  logic [2:0] code;
  logic       valid, dropped, pressed;

  int checks = 0;
  int passes = 0;
  int exp_q[$];

  assign ack = dir_ack | mon_ack;

  always #5 clk = ~clk;

  btn_encoder_8to3 #(
    .DEBOUNCE_CYCLES(Deb),
    .CNT_W          (16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_raw),
    .ack    (ack),
    .code   (code),
    .valid  (valid),
    .dropped(dropped),
    .pressed(pressed)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    btn_raw = v;
    tick(n);
  endtask

  task automatic ack_pulse();
    dir_ack = 1'b1;
    tick(1);
    dir_ack = 1'b0;
  endtask

  function automatic int msb_index(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_code"}, int'(code), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_dropped"}, int'(dropped), 0);
    chk({tag, "_pressed"}, int'(pressed), 0);
  endtask

  // A new event is a valid that rises, or stays high across an edge that consumed an ack.
  initial begin : monitor
    logic prev_valid, prev_acked, ack_now;
    int   e;
    prev_valid = 1'b0;
    prev_acked = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
        prev_acked = 1'b0;
        mon_ack    = 1'b0;
      end else begin
        if (valid && (!prev_valid || prev_acked)) begin
          if (exp_q.size() == 0) chk("unexpected_event", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("event_code", int'(code), e);
          end
        end
        mon_ack    = auto_ack && valid;
        ack_now    = mon_ack || dir_ack;
        prev_acked = ack_now && valid;
        prev_valid = valid;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin : stimulus
    logic [7:0] v;
    logic [7:0] model_stable;

    tick(3);
    chk_all_zero("reset");

    // 1: single press, latency to edge DEBOUNCE_CYCLES+4, held until ack.
    reset = 1'b0;
    btn_raw = 8'h04;
    exp_q.push_back(2);
    tick(7);
    chk("t1_valid_e7", int'(valid), 0);
    chk("t1_pressed_e7", int'(pressed), 0);
    tick(1);
    chk("t1_valid_e8", int'(valid), 1);
    chk("t1_code_e8", int'(code), 2);
    chk("t1_pressed_e8", int'(pressed), 1);
    tick(5);
    chk("t1_valid_held", int'(valid), 1);
    ack_pulse();
    chk("t1_valid_acked", int'(valid), 0);
    hold(8'h00, 12);
    chk("t1_pressed_rel", int'(pressed), 0);

    // 2: bounce on bit 5 then steady.
    exp_q.push_back(5);
    for (int i = 0; i < 5; i++) hold((i % 2 == 0) ? 8'h20 : 8'h00, 2);
    hold(8'h20, 15);
    chk("t2_valid", int'(valid), 1);
    chk("t2_code", int'(code), 5);
    chk("t2_dropped", int'(dropped), 0);
    ack_pulse();
    hold(8'h00, 12);
    chk("t2_valid_after", int'(valid), 0);

    // 3: priority and second press after ack.
    exp_q.push_back(7);
    exp_q.push_back(0);
    hold(8'h92, 10);
    chk("t3_code7", int'(code), 7);
    hold(8'h00, 10);
    chk("t3_valid_unacked", int'(valid), 1);
    ack_pulse();
    chk("t3_valid_acked", int'(valid), 0);
    hold(8'h01, 10);
    chk("t3_valid2", int'(valid), 1);
    chk("t3_code0", int'(code), 0);
    ack_pulse();
    hold(8'h00, 12);

    // 4: second press while pending is dropped.
    exp_q.push_back(3);
    hold(8'h08, 10);
    hold(8'h00, 10);
    hold(8'h40, 10);
    chk("t4_valid", int'(valid), 1);
    chk("t4_code", int'(code), 3);
    chk("t4_dropped", int'(dropped), 1);
    ack_pulse();
    chk("t4_valid_acked", int'(valid), 0);
    chk("t4_dropped_acked", int'(dropped), 0);
    hold(8'h00, 12);

    // 5: long hold gives no repeats.
    exp_q.push_back(1);
    hold(8'h02, 20);
    chk("t5_code", int'(code), 1);
    ack_pulse();
    hold(8'h02, 79);
    chk("t5_no_repeat", int'(valid), 0);
    chk("t5_pressed", int'(pressed), 1);
    hold(8'h00, 12);
    chk("t5_pressed_rel", int'(pressed), 0);
    exp_q.push_back(1);
    hold(8'h02, 10);
    chk("t5_repress", int'(valid), 1);
    ack_pulse();
    hold(8'h00, 12);

    // 6: reset mid-debounce, then reset with valid and dropped set.
    btn_raw = 8'h10;
    tick(4);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 chk_all_zero("t6_rst_debounce");
    tick(2);
    reset = 1'b0;
    exp_q.push_back(4);
    tick(7);
    chk("t6_valid_e7", int'(valid), 0);
    tick(1);
    chk("t6_valid_e8", int'(valid), 1);
    chk("t6_code_e8", int'(code), 4);
    hold(8'h00, 10);
    hold(8'h08, 10);
    chk("t6_dropped", int'(dropped), 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 chk_all_zero("t6_rst_valid");
    tick(2);
    btn_raw = 8'h00;
    reset = 1'b0;
    hold(8'h00, 12);
    chk("t6_quiet", int'(valid), 0);

    // Random: long holds become debounced state, short glitches never do.
    auto_ack = 1'b1;
    model_stable = 8'h00;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        hold(8'($urandom), $urandom_range(1, Deb - 1));
      end else begin
        v = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(1, 255));
        if (model_stable == 8'h00 && v != 8'h00) exp_q.push_back(msb_index(v));
        model_stable = v;
        hold(v, $urandom_range(Deb + 6, 16));
        chk("rnd_pressed", int'(pressed), int'(v != 8'h00));
        chk("rnd_dropped", int'(dropped), 0);
      end
    end
    hold(8'h00, 20);
    chk("rnd_pending_events", exp_q.size(), 0);
    chk("rnd_valid_end", int'(valid), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
